if_fetch_buffer: RTL and testbench

//  Parametrised N-wide instruction fetch stage with a circular fetch queue between I-memory and dispatch.

---
 rtl/if_fetch_buffer.sv | 198 +++++++++++++++++++
 tb/tb_if_fetch_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buffer.sv
// Purpose: N-wide instruction fetch with a circular fetch queue between I-memory and dispatch.
// Latency: a group requested in cycle t with a 1-cycle memory is visible at the queue head in t+2.
// Backpressure: a request is issued only when the queue has room for a whole group; dispatch pops 0..N per cycle.

`ifndef NOP
`define NOP 32'h0000_0013
`endif

package if_fetch_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
  } IF_DP_PACKET;
endpackage

module if_fetch_buffer
  import if_fetch_pkg::*;
#(
  parameter int unsigned     FETCH_WIDTH = 2,
  parameter int unsigned     DEPTH       = 8,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 squash_valid,
  input  logic [XLEN-1:0]                      squashed_PC,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]     dp_take,
  input  logic                                 Imem2proc_valid,
  input  logic [FETCH_WIDTH-1:0][63:0]         Imem2proc_data,
  output logic                                 proc2Imem_req,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0]     proc2Imem_addr,
  output IF_DP_PACKET [FETCH_WIDTH-1:0]        if_dp_packet
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]   WIDTH_C   = CW'(FETCH_WIDTH);
  localparam logic [XLEN-1:0] GRP_BYTES = XLEN'(4 * FETCH_WIDTH);

  // READY: may issue; WAIT: request outstanding; DROP: outstanding response is stale.
  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] grp_pc_q, grp_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            post_rst_q, post_rst_d;
  IF_DP_PACKET     queue_q [DEPTH];
  IF_DP_PACKET     queue_d [DEPTH];

  logic [CW-1:0]   take_ext;
  logic [CW-1:0]   eff_take;
  logic            space_ok;
  logic            enq;
  logic [XLEN-1:0] lane_pc;

  function automatic logic [XLEN-1:0] blk_addr(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:3], 3'b000};
  endfunction

  // Clamp the dispatch pop to what is present, and decide request / enqueue for this cycle.
  always_comb begin
    take_ext      = CW'(dp_take);
    eff_take      = (take_ext > count_q) ? count_q : take_ext;
    space_ok      = (DEPTH_C - count_q) >= WIDTH_C;
    proc2Imem_req = !reset && (state_q == S_READY) && space_ok && !squash_valid;
    enq           = (state_q == S_WAIT) && Imem2proc_valid && !squash_valid;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      proc2Imem_addr[i] = blk_addr(fetch_pc_q + XLEN'(4 * i));
    end
  end

  // Next-state for the FSM, fetch PC and queue pointers; squash overrides everything else.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    grp_pc_d   = grp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    post_rst_d = post_rst_q;
    queue_d    = queue_q;
    lane_pc    = '0;

    if (squash_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = squashed_PC;
      case (state_q)
        // A response landing with the squash is stale and consumed right here.
        S_WAIT:  state_d = Imem2proc_valid ? S_READY : S_DROP;
        S_DROP:  state_d = Imem2proc_valid ? S_READY : S_DROP;
        default: state_d = S_READY;
      endcase
    end else begin
      case (state_q)
        S_READY: begin
          if (proc2Imem_req) begin
            grp_pc_d   = fetch_pc_q;
            state_d    = S_WAIT;
            post_rst_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (Imem2proc_valid) begin
            fetch_pc_d = fetch_pc_q + GRP_BYTES;
            state_d    = S_READY;
          end
        end
        S_DROP: begin
          if (Imem2proc_valid) begin
            state_d = S_READY;
          end
        end
        default: state_d = S_READY;
      endcase

      // Whole group goes in at once; room was guaranteed when the request was issued.
      if (enq) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          lane_pc = grp_pc_q + XLEN'(4 * i);
          queue_d[tail_q + PW'(i)].valid = 1'b1;
          queue_d[tail_q + PW'(i)].PC    = lane_pc;
          queue_d[tail_q + PW'(i)].NPC   = lane_pc + XLEN'(4);
          queue_d[tail_q + PW'(i)].inst  = lane_pc[2] ? Imem2proc_data[i][63:32]
                                                      : Imem2proc_data[i][31:0];
        end
        tail_d = tail_q + PW'(FETCH_WIDTH);
      end

      head_d  = head_q + PW'(eff_take);
      count_d = count_q + (enq ? WIDTH_C : {CW{1'b0}}) - eff_take;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_READY;
      fetch_pc_q <= RESET_PC;
      grp_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      grp_pc_q   <= grp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      post_rst_q <= post_rst_d;
    end
  end

  // Queue storage needs no reset: slots outside head..head+count are never exposed.
  always_ff @(posedge clock) begin
    queue_q <= queue_d;
  end

  // Present the oldest FETCH_WIDTH entries; empty slots read as invalid NOPs.
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if_dp_packet[k] = queue_q[head_q + PW'(k)];
      if (!(CW'(k) < count_q)) begin
        if_dp_packet[k].valid = 1'b0;
        if_dp_packet[k].inst  = `NOP;
        if_dp_packet[k].PC    = '0;
        if_dp_packet[k].NPC   = '0;
      end
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is a protocol error, except one orphaned by a reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(Imem2proc_valid && (state_q == S_READY) && !post_rst_q))
        else $error("if_fetch_buffer: Imem2proc_valid with no request outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;
  import if_fetch_pkg::*;

  localparam int          W        = 2;
  localparam int          D        = 8;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic                 clock;
  logic                 reset;
  logic                 squash_valid;
  logic [31:0]          squashed_PC;
  logic [1:0]           dp_take;
  logic                 Imem2proc_valid;
  logic [W-1:0][63:0]   Imem2proc_data;
  logic                 proc2Imem_req;
  logic [W-1:0][31:0]   proc2Imem_addr;
  IF_DP_PACKET [W-1:0]  if_dp_packet;

  int checks = 0;
  int fails  = 0;

  if_fetch_buffer #(
    .FETCH_WIDTH(W),
    .DEPTH      (D),
    .RESET_PC   (32'h0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .squash_valid   (squash_valid),
    .squashed_PC    (squashed_PC),
    .dp_take        (dp_take),
    .Imem2proc_valid(Imem2proc_valid),
    .Imem2proc_data (Imem2proc_data),
    .proc2Imem_req  (proc2Imem_req),
    .proc2Imem_addr (proc2Imem_addr),
    .if_dp_packet   (if_dp_packet)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory image: the instruction word at byte address p is 0xA0000000 ^ p.
  function automatic IF_DP_PACKET exp_pkt(input logic [31:0] pc);
    IF_DP_PACKET p;
    p.valid = 1'b1;
    p.inst  = 32'hA000_0000 ^ pc;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    squash_valid    = 1'b0;
    squashed_PC     = 32'h0;
    dp_take         = 2'd0;
    Imem2proc_valid = 1'b0;
    Imem2proc_data  = '0;
  endtask

  task automatic respond(input logic [31:0] grp);
    logic [31:0] a;
    Imem2proc_valid = 1'b1;
    for (int i = 0; i < W; i++) begin
      a      = grp + 32'(4 * i);
      a[2:0] = 3'b000;
      Imem2proc_data[i] = {32'hA000_0000 ^ (a + 32'd4), 32'hA000_0000 ^ a};
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    checks++; if (proc2Imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b expected 0", proc2Imem_req); end
    checks++; if (if_dp_packet[0].valid !== 1'b0) begin fails++; $display("FAIL rst_v0: got %b expected 0", if_dp_packet[0].valid); end
    checks++; if (if_dp_packet[1].valid !== 1'b0) begin fails++; $display("FAIL rst_v1: got %b expected 0", if_dp_packet[1].valid); end
    checks++; if (if_dp_packet[0].inst !== NOP_INST) begin fails++; $display("FAIL rst_nop0: got %h expected %h", if_dp_packet[0].inst, NOP_INST); end
    checks++; if (if_dp_packet[1].inst !== NOP_INST) begin fails++; $display("FAIL rst_nop1: got %h expected %h", if_dp_packet[1].inst, NOP_INST); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (proc2Imem_req !== 1'b1) begin fails++; $display("FAIL rst_first_req: got %b expected 1", proc2Imem_req); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    checks++; if (proc2Imem_req !== 1'b1) begin fails++; $display("FAIL t1_req: got %b expected 1", proc2Imem_req); end
    checks++; if (proc2Imem_addr[0] !== 32'h0) begin fails++; $display("FAIL t1_addr0: got %h expected 0", proc2Imem_addr[0]); end
    checks++; if (proc2Imem_addr[1] !== 32'h0) begin fails++; $display("FAIL t1_addr1: got %h expected 0", proc2Imem_addr[1]); end
    step(); respond(32'h0); #1;
    checks++; if (proc2Imem_req !== 1'b0) begin fails++; $display("FAIL t1_pulse: got %b expected 0", proc2Imem_req); end
    step(); idle_inputs(); #1;
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h0)) begin fails++; $display("FAIL t1_head0: got %h expected %h", if_dp_packet[0], exp_pkt(32'h0)); end
    checks++; if (if_dp_packet[1] !== exp_pkt(32'h4)) begin fails++; $display("FAIL t1_head1: got %h expected %h", if_dp_packet[1], exp_pkt(32'h4)); end
    checks++; if (proc2Imem_addr[0] !== 32'h8) begin fails++; $display("FAIL t1_next_addr: got %h expected 8", proc2Imem_addr[0]); end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      if (proc2Imem_req === 1'b1) nreq++;
      checks++; if (proc2Imem_addr[0] !== 32'(8 * g)) begin fails++; $display("FAIL t2_addr g%0d: got %h expected %h", g, proc2Imem_addr[0], 32'(8 * g)); end
      step(); respond(32'(8 * g)); #1;
      step(); idle_inputs(); #1;
    end
    for (int c = 0; c < 3; c++) begin
      if (proc2Imem_req === 1'b1) nreq++;
      step(); #1;
    end
    checks++; if (nreq !== 4) begin fails++; $display("FAIL t2_nreq: got %0d expected 4", nreq); end
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h0)) begin fails++; $display("FAIL t2_full_head: got %h expected %h", if_dp_packet[0], exp_pkt(32'h0)); end
    dp_take = 2'd2; #1;
    checks++; if (proc2Imem_req !== 1'b0) begin fails++; $display("FAIL t2_still_full: got %b expected 0", proc2Imem_req); end
    step(); dp_take = 2'd0; #1;
    checks++; if (proc2Imem_req !== 1'b1) begin fails++; $display("FAIL t2_resume: got %b expected 1", proc2Imem_req); end
    checks++; if (proc2Imem_addr[0] !== 32'h20) begin fails++; $display("FAIL t2_resume_addr: got %h expected 20", proc2Imem_addr[0]); end
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h8)) begin fails++; $display("FAIL t2_popped_head: got %h expected %h", if_dp_packet[0], exp_pkt(32'h8)); end
  endtask

  task automatic test_squash_wait();
    do_reset();
    step(); squash_valid = 1'b1; squashed_PC = 32'h100; #1;
    checks++; if (proc2Imem_req !== 1'b0) begin fails++; $display("FAIL t3_sq_req: got %b expected 0", proc2Imem_req); end
    step(); idle_inputs(); #1;
    checks++; if (proc2Imem_req !== 1'b0) begin fails++; $display("FAIL t3_drop_req: got %b expected 0", proc2Imem_req); end
    checks++; if (if_dp_packet[0].valid !== 1'b0) begin fails++; $display("FAIL t3_empty: got %b expected 0", if_dp_packet[0].valid); end
    step(); #1;
    step(); respond(32'h0); #1;
    checks++; if (proc2Imem_req !== 1'b0) begin fails++; $display("FAIL t3_late_req: got %b expected 0", proc2Imem_req); end
    step(); idle_inputs(); #1;
    checks++; if (proc2Imem_req !== 1'b1) begin fails++; $display("FAIL t3_redir_req: got %b expected 1", proc2Imem_req); end
    checks++; if (proc2Imem_addr[0] !== 32'h100) begin fails++; $display("FAIL t3_addr0: got %h expected 100", proc2Imem_addr[0]); end
    checks++; if (proc2Imem_addr[1] !== 32'h100) begin fails++; $display("FAIL t3_addr1: got %h expected 100", proc2Imem_addr[1]); end
    checks++; if (if_dp_packet[0].valid !== 1'b0) begin fails++; $display("FAIL t3_not_enq: got %b expected 0", if_dp_packet[0].valid); end
    step(); respond(32'h100); #1;
    step(); idle_inputs(); #1;
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h100)) begin fails++; $display("FAIL t3_head0: got %h expected %h", if_dp_packet[0], exp_pkt(32'h100)); end
    checks++; if (if_dp_packet[1] !== exp_pkt(32'h104)) begin fails++; $display("FAIL t3_head1: got %h expected %h", if_dp_packet[1], exp_pkt(32'h104)); end
  endtask

  task automatic test_squash_coincident();
    do_reset();
    step(); respond(32'h0); #1;
    step(); idle_inputs(); #1;
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h0)) begin fails++; $display("FAIL t4_pre: got %h expected %h", if_dp_packet[0], exp_pkt(32'h0)); end
    step(); respond(32'h8); squash_valid = 1'b1; squashed_PC = 32'h200; #1;
    checks++; if (proc2Imem_req !== 1'b0) begin fails++; $display("FAIL t4_sq_req: got %b expected 0", proc2Imem_req); end
    step(); idle_inputs(); #1;
    checks++; if (if_dp_packet[0].valid !== 1'b0) begin fails++; $display("FAIL t4_flush0: got %b expected 0", if_dp_packet[0].valid); end
    checks++; if (if_dp_packet[1].valid !== 1'b0) begin fails++; $display("FAIL t4_flush1: got %b expected 0", if_dp_packet[1].valid); end
    checks++; if (proc2Imem_req !== 1'b1) begin fails++; $display("FAIL t4_ready_req: got %b expected 1", proc2Imem_req); end
    checks++; if (proc2Imem_addr[0] !== 32'h200) begin fails++; $display("FAIL t4_addr: got %h expected 200", proc2Imem_addr[0]); end
    step(); respond(32'h200); #1;
    checks++; if (if_dp_packet[0].valid !== 1'b0) begin fails++; $display("FAIL t4_no_stale: got %b expected 0", if_dp_packet[0].valid); end
    step(); idle_inputs(); #1;
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h200)) begin fails++; $display("FAIL t4_head0: got %h expected %h", if_dp_packet[0], exp_pkt(32'h200)); end
    checks++; if (if_dp_packet[1] !== exp_pkt(32'h204)) begin fails++; $display("FAIL t4_head1: got %h expected %h", if_dp_packet[1], exp_pkt(32'h204)); end
  endtask

  task automatic test_underflow_wrap();
    do_reset();
    step(); respond(32'h0); #1;
    step(); idle_inputs(); dp_take = 2'd1; #1;
    checks++; if (proc2Imem_addr[0] !== 32'h8) begin fails++; $display("FAIL t5_addr8: got %h expected 8", proc2Imem_addr[0]); end
    step(); dp_take = 2'd2; #1;
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h4)) begin fails++; $display("FAIL t5_one_left: got %h expected %h", if_dp_packet[0], exp_pkt(32'h4)); end
    checks++; if (if_dp_packet[1].valid !== 1'b0) begin fails++; $display("FAIL t5_slot1_v: got %b expected 0", if_dp_packet[1].valid); end
    checks++; if (if_dp_packet[1].inst !== NOP_INST) begin fails++; $display("FAIL t5_slot1_nop: got %h expected %h", if_dp_packet[1].inst, NOP_INST); end
    step(); dp_take = 2'd0; respond(32'h8); #1;
    checks++; if (if_dp_packet[0].valid !== 1'b0) begin fails++; $display("FAIL t5_empty: got %b expected 0", if_dp_packet[0].valid); end
    step(); idle_inputs(); #1;
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h8)) begin fails++; $display("FAIL t5_head0: got %h expected %h", if_dp_packet[0], exp_pkt(32'h8)); end
    checks++; if (if_dp_packet[1] !== exp_pkt(32'hC)) begin fails++; $display("FAIL t5_head1: got %h expected %h", if_dp_packet[1], exp_pkt(32'hC)); end
    for (int g = 2; g < 8; g++) begin
      checks++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr[0] !== 32'(8 * g)) begin fails++; $display("FAIL t5_wrap_req g%0d: got req=%b addr=%h expected req=1 addr=%h", g, proc2Imem_req, proc2Imem_addr[0], 32'(8 * g)); end
      dp_take = 2'd2;
      step(); dp_take = 2'd0; respond(32'(8 * g)); #1;
      step(); idle_inputs(); #1;
      checks++; if (if_dp_packet[0] !== exp_pkt(32'(8 * g))) begin fails++; $display("FAIL t5_wrap_h0 g%0d: got %h expected %h", g, if_dp_packet[0], exp_pkt(32'(8 * g))); end
      checks++; if (if_dp_packet[1] !== exp_pkt(32'(8 * g + 4))) begin fails++; $display("FAIL t5_wrap_h1 g%0d: got %h expected %h", g, if_dp_packet[1], exp_pkt(32'(8 * g + 4))); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(); respond(32'h0); #1;
    step(); idle_inputs(); #1;
    step(); #1;
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h0)) begin fails++; $display("FAIL t6_pre: got %h expected %h", if_dp_packet[0], exp_pkt(32'h0)); end
    reset = 1'b1;
    #1;
    checks++; if (if_dp_packet[0].valid !== 1'b0) begin fails++; $display("FAIL t6_async_v: got %b expected 0", if_dp_packet[0].valid); end
    checks++; if (if_dp_packet[0].inst !== NOP_INST) begin fails++; $display("FAIL t6_async_nop: got %h expected %h", if_dp_packet[0].inst, NOP_INST); end
    checks++; if (proc2Imem_req !== 1'b0) begin fails++; $display("FAIL t6_async_req: got %b expected 0", proc2Imem_req); end
    #4;
    reset = 1'b0;
    respond(32'h8);
    #1;
    checks++; if (proc2Imem_req !== 1'b1) begin fails++; $display("FAIL t6_req: got %b expected 1", proc2Imem_req); end
    checks++; if (proc2Imem_addr[0] !== 32'h0) begin fails++; $display("FAIL t6_addr: got %h expected 0", proc2Imem_addr[0]); end
    step(); idle_inputs(); #1;
    checks++; if (if_dp_packet[0].valid !== 1'b0) begin fails++; $display("FAIL t6_late_ignored: got %b expected 0", if_dp_packet[0].valid); end
    step(); respond(32'h0); #1;
    step(); idle_inputs(); #1;
    checks++; if (if_dp_packet[0] !== exp_pkt(32'h0)) begin fails++; $display("FAIL t6_refetch: got %h expected %h", if_dp_packet[0], exp_pkt(32'h0)); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_squash_wait();
    test_squash_coincident();
    test_underflow_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
